// File: rtl/pwm_capture.sv
// Single-shot PWM high-time capture: after a trigger, counts clk cycles with ext_pwm high
// and latches the count on the falling edge, raising an interrupt flag.
module pwm_capture (
    input  logic        clk,
    input  logic        rst,
    input  logic        oe,
    input  logic        clr,
    input  logic        trigger,
    input  logic        ext_pwm,
    input  logic        int_clr,
    output logic        int_flag,
    output logic [31:0] data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] count;
    logic [31:0] capture;

    logic count_zero;
    logic count_first;
    logic count_inc;
    logic cap_load;
    logic cap_zero;
    logic int_set;
    logic int_zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // clr outranks trigger; both outrank the normal state progression
    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = IDLE;
        end else if (trigger) begin
            state_next = ARMED;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                ARMED:   if (ext_pwm) state_next = MEASURE;
                MEASURE: if (!ext_pwm) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        count_zero  = 1'b0;
        count_first = 1'b0;
        count_inc   = 1'b0;
        cap_load    = 1'b0;
        cap_zero    = 1'b0;
        int_set     = 1'b0;
        int_zero    = 1'b0;
        if (clr) begin
            count_zero = 1'b1;
            cap_zero   = 1'b1;
        end else if (trigger) begin
            count_zero = 1'b1;
            int_zero   = 1'b1;
        end else begin
            case (state)
                ARMED: begin
                    if (ext_pwm) count_first = 1'b1;
                end
                MEASURE: begin
                    if (ext_pwm) begin
                        count_inc = 1'b1;
                    end else begin
                        cap_load = 1'b1;
                        int_set  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (int_clr) int_zero = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (count_zero) begin
            count <= '0;
        end else if (count_first) begin
            count <= 32'd1;
        end else if (count_inc) begin
            if (count != '1) count <= count + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            capture <= '0;
        end else if (cap_zero) begin
            capture <= '0;
        end else if (cap_load) begin
            capture <= count;
        end
    end

    // a completing capture wins over a simultaneous int_clr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_flag <= 1'b0;
        end else if (int_set) begin
            int_flag <= 1'b1;
        end else if (int_zero) begin
            int_flag <= 1'b0;
        end
    end

    assign data = oe ? capture : 32'hZZZZ_ZZZZ;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture; the data bus carries a pull-up so a released bus reads all ones.
module tb_pwm_capture;

    logic       clk;
    logic       rst;
    logic       oe;
    logic       clr;
    logic       trigger;
    logic       ext_pwm;
    logic       int_clr;
    logic       int_flag;
    tri1 [31:0] data;

    int unsigned total;
    int unsigned bad;

    pwm_capture dut (
        .clk      (clk),
        .rst      (rst),
        .oe       (oe),
        .clr      (clr),
        .trigger  (trigger),
        .ext_pwm  (ext_pwm),
        .int_clr  (int_clr),
        .int_flag (int_flag),
        .data     (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        oe      = 1'b1;
        clr     = 1'b0;
        trigger = 1'b0;
        ext_pwm = 1'b0;
        int_clr = 1'b0;
        #1;
        check("rst_data", data, 32'd0);
        check("rst_int", {31'd0, int_flag}, 32'd0);
        oe = 1'b0;
        #1;
        check("rst_data_hiz", data, 32'hFFFF_FFFF);
        oe = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(2);

        // basic 1000-cycle pulse
        pulse_trigger();
        ext_pwm = 1'b1;
        tick(1000);
        check("m1000_pre_int", {31'd0, int_flag}, 32'd0);
        check("m1000_pre_data", data, 32'd0);
        ext_pwm = 1'b0;
        tick(1);
        check("m1000_data", data, 32'd1000);
        check("m1000_int", {31'd0, int_flag}, 32'd1);

        // retrigger after idle, long pulse
        tick(1000);
        pulse_trigger();
        check("retrig_int", {31'd0, int_flag}, 32'd0);
        check("retrig_data", data, 32'd1000);
        ext_pwm = 1'b1;
        tick(2000);
        check("m2000_int", {31'd0, int_flag}, 32'd0);
        check("m2000_data", data, 32'd1000);
        tick(5000);
        ext_pwm = 1'b0;
        tick(1);
        check("m7000_data", data, 32'd7000);
        check("m7000_int", {31'd0, int_flag}, 32'd1);

        // interrupt clear, and clear colliding with a capture
        int_clr = 1'b1;
        tick(1);
        int_clr = 1'b0;
        check("intclr_int", {31'd0, int_flag}, 32'd0);
        check("intclr_data", data, 32'd7000);
        pulse_trigger();
        ext_pwm = 1'b1;
        tick(5);
        ext_pwm = 1'b0;
        int_clr = 1'b1;
        tick(1);
        int_clr = 1'b0;
        check("collide_int", {31'd0, int_flag}, 32'd1);
        check("collide_data", data, 32'd5);

        // abort mid-measurement while the pulse stays high
        pulse_trigger();
        ext_pwm = 1'b1;
        tick(300);
        pulse_trigger();
        check("abort_int", {31'd0, int_flag}, 32'd0);
        check("abort_data", data, 32'd5);
        tick(200);
        ext_pwm = 1'b0;
        tick(1);
        check("abort_result", data, 32'd200);
        check("abort_result_int", {31'd0, int_flag}, 32'd1);

        // trigger held high keeps the block armed
        trigger = 1'b1;
        ext_pwm = 1'b1;
        tick(6);
        ext_pwm = 1'b0;
        tick(2);
        check("hold_data", data, 32'd200);
        check("hold_int", {31'd0, int_flag}, 32'd0);
        ext_pwm = 1'b1;
        tick(1);
        trigger = 1'b0;
        tick(4);
        ext_pwm = 1'b0;
        tick(1);
        check("hold_release_data", data, 32'd4);

        // clr during MEASURE: capture cleared, no late capture
        pulse_trigger();
        ext_pwm = 1'b1;
        tick(50);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_data", data, 32'd0);
        check("clr_int", {31'd0, int_flag}, 32'd0);
        tick(10);
        ext_pwm = 1'b0;
        tick(2);
        check("clr_after_data", data, 32'd0);
        check("clr_after_int", {31'd0, int_flag}, 32'd0);

        // clr leaves a pending interrupt alone, and beats a simultaneous trigger
        pulse_trigger();
        ext_pwm = 1'b1;
        tick(3);
        ext_pwm = 1'b0;
        tick(1);
        check("short_data", data, 32'd3);
        clr     = 1'b1;
        trigger = 1'b1;
        tick(1);
        clr     = 1'b0;
        trigger = 1'b0;
        check("clr_keep_int", {31'd0, int_flag}, 32'd1);
        check("clr_keep_data", data, 32'd0);
        ext_pwm = 1'b1;
        tick(3);
        ext_pwm = 1'b0;
        tick(1);
        check("clr_beats_trig", data, 32'd0);

        // bus release while holding a nonzero result
        pulse_trigger();
        ext_pwm = 1'b1;
        tick(9);
        ext_pwm = 1'b0;
        tick(1);
        check("oe_on", data, 32'd9);
        oe = 1'b0;
        #1;
        check("oe_off", data, 32'hFFFF_FFFF);
        oe = 1'b1;
        #1;
        check("oe_back", data, 32'd9);

        // asynchronous reset between clock edges
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_data", data, 32'd0);
        check("async_rst_int", {31'd0, int_flag}, 32'd0);
        tick(1);
        rst = 1'b1;
        tick(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
